restador_serial: RTL and testbench
==================================

Name: restador_serial

Overview:
- Bit-serial two's-complement subtractor: computes D = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Sequential counterpart to the combinational ripple adder in the lab datapath. It trades WIDTH cycles of latency for one bit-cell of logic.
- Driven by a start/done handshake from the lab control FSM.

Parameters:
WIDTH, 4, operand/result width in bits (≥2)

Ports:
clk    input   1      system clock, rising-edge active
rst_n  input   1      asynchronous reset, active low
start  input   1      request; sampled only when accepting (IDLE or DONE)
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
bin    input   1      borrow-in, captured on accepted start
busy   output  1      high while operation in progress (SHIFT)
done   output  1      one-cycle pulse: d/bout valid
d      output  WIDTH  difference, registered, held until next completion
bout   output  1      borrow-out of MSB, registered, held with d

Behaviour:
- Interface is fixed: one clock `clk`; `rst_n` is asynchronous, active low.
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, d=0, bout=0, internal shift regs/borrow/counter=0.
- FSM states:
  - IDLE: busy=0, done=0. On start=1, go to SHIFT.
  - SHIFT: busy=1. After bit WIDTH−1, go to DONE.
  - DONE: done=1, busy=0. Next state is SHIFT if start=1, else IDLE.
- Accepted start at edge k: load sa←a, sb←b, br←bin, cnt←0.
- SHIFT, each edge:
  - x = sa[0], y = sb[0]
  - diff = x^y^br
  - nbr = (~x&y) | (~(x^y)&br)
  - sd ← {diff, sd[WIDTH-1:1]}; sa, sb shift right; br←nbr; cnt++
  - When cnt==WIDTH−1, transfer to DONE.
- Latency: SHIFT occupies edges k+1..k+WIDTH. At edge k+WIDTH: d←final sd, bout←final borrow, state←DONE. done is high for exactly the cycle after edge k+WIDTH. Start-to-done is WIDTH cycles.
- d and bout change only at completion. Partial results never appear on d.
- start while in SHIFT: ignored, no queuing. a/b/bin changes during SHIFT have no effect.
- start=1 in the DONE cycle: accepted, back-to-back. The next result is ready WIDTH cycles later, with no IDLE gap.
- start held high continuously: consecutive operations, one done per WIDTH+... cycles as defined by the above.
- Reset mid-operation: aborts immediately, no done pulse, d/bout cleared to 0.
- Arithmetic is modulo 2^WIDTH. bout=1 iff unsigned A < B+Bin.

Optional Feature:
RESTA_OVF_EN
- Defined: adds output port `ovf` (1 bit, registered, reset 0), updated together with d/bout. ovf = borrow into MSB XOR borrow out of MSB, i.e. signed two's-complement overflow.
- Undefined: no `ovf` port and no extra logic. All other behaviour is identical.

Test Plan:
- a=9, b=3, bin=0, start pulse at edge 0 -> busy=1 edges 1–4; done=1 one cycle after edge 4; d=6, bout=0.
- a=3, b=9, bin=0 -> d=10 (4'hA), bout=1. Then a=0, b=0, bin=1 -> d=15, bout=1.
- Back-to-back: start held during DONE with a=15, b=15, bin=0 -> second done exactly 4 cycles later, d=0, bout=0; no IDLE cycle between.
- Start pulses and operand changes during SHIFT -> ignored; result equals operands captured at the accepted start; only one done pulse.
- rst_n low at cycle 2 of an operation -> immediate busy=0, done=0, d=0, bout=0; no done pulse after release; a new start works normally.
- RESTA_OVF_EN defined: a=8, b=1 -> d=7, bout=0, ovf=1; a=5, b=2 -> d=3, ovf=0.

Source files
------------

// File: rtl/restador_serial.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, LSB first, one full-subtractor cell.
// Optional macro RESTA_OVF_EN adds a registered signed-overflow output `ovf`.
module restador_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
`ifdef RESTA_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic fs_diff(input logic x, input logic y, input logic br);
      return x ^ y ^ br;
   endfunction

   function automatic logic fs_borrow(input logic x, input logic y, input logic br);
      return (~x & y) | (~(x ^ y) & br);
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sd_q, sd_d, d_q, d_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             diff_s, nbr_s, last_s, accept_s;
`ifdef RESTA_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign diff_s   = fs_diff(sa_q[0], sb_q[0], br_q);
   assign nbr_s    = fs_borrow(sa_q[0], sb_q[0], br_q);
   assign last_s   = (cnt_q == CNT_LAST);
   assign accept_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = start  ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: state_d = last_s ? ST_DONE  : ST_SHIFT;
         ST_DONE:  state_d = start  ? ST_SHIFT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Status outputs, decoded from the next state so they are registered
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         ST_IDLE:  begin busy_d = 1'b0; done_d = 1'b0; end
         ST_SHIFT: begin busy_d = 1'b1; done_d = 1'b0; end
         ST_DONE:  begin busy_d = 1'b0; done_d = 1'b1; end
         default:  begin busy_d = 1'b0; done_d = 1'b0; end
      endcase
   end

   // Datapath: operand capture, serial shift, and result transfer on the last bit
   always_comb begin
      sa_d   = sa_q;
      sb_d   = sb_q;
      sd_d   = sd_q;
      br_d   = br_q;
      cnt_d  = cnt_q;
      d_d    = d_q;
      bout_d = bout_q;
`ifdef RESTA_OVF_EN
      ovf_d  = ovf_q;
`endif
      if (accept_s) begin
         sa_d  = a;
         sb_d  = b;
         br_d  = bin;
         cnt_d = {CW{1'b0}};
      end else if (state_q == ST_SHIFT) begin
         sa_d  = {1'b0, sa_q[WIDTH-1:1]};
         sb_d  = {1'b0, sb_q[WIDTH-1:1]};
         sd_d  = {diff_s, sd_q[WIDTH-1:1]};
         br_d  = nbr_s;
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         if (last_s) begin
            d_d    = {diff_s, sd_q[WIDTH-1:1]};
            bout_d = nbr_s;
`ifdef RESTA_OVF_EN
            // br_q is the borrow into the MSB cell at this step
            ovf_d  = br_q ^ nbr_s;
`endif
         end else begin
            d_d    = d_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q   <= {WIDTH{1'b0}};
         sb_q   <= {WIDTH{1'b0}};
         sd_q   <= {WIDTH{1'b0}};
         br_q   <= 1'b0;
         cnt_q  <= {CW{1'b0}};
         d_q    <= {WIDTH{1'b0}};
         bout_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef RESTA_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         sd_q   <= sd_d;
         br_q   <= br_d;
         cnt_q  <= cnt_d;
         d_q    <= d_d;
         bout_q <= bout_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef RESTA_OVF_EN
         ovf_q  <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign d    = d_q;
   assign bout = bout_q;
`ifdef RESTA_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_restador_serial.sv
// Directed self-checking bench for restador_serial (WIDTH=4), inputs and samples on the falling edge.
module tb_restador_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic       bin = 1'b0;
   logic       busy, done, bout;
   logic [3:0] d;
`ifdef RESTA_OVF_EN
   logic       ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] last_d = 4'd0;

   restador_serial #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
`ifdef RESTA_OVF_EN
      .ovf   (ovf),
`endif
      .bout  (bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One operation with start/operand noise during SHIFT; full cycle-by-cycle timing checks.
   task automatic do_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic tbin, input logic [3:0] ed, input logic eb);
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_v; bin = tbin;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_nodone"}, done, 0);
         chk({tag, "_hold"}, d, last_d);
         a = ~ta; b = ~tb_v; bin = ~tbin;
         start = (i == 1);
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_d"}, d, ed);
      chk({tag, "_bout"}, bout, eb);
      @(negedge clk);
      chk({tag, "_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      last_d = ed;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_d", d, 0);
      chk("rst_bout", bout, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      do_op("op9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
      do_op("op3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
      do_op("op0m0b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);

      // Back-to-back: start held into the DONE cycle
      @(negedge clk);
      start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; a = 4'd15; b = 4'd15; bin = 1'b0;
      @(negedge clk);
      chk("b2b_done1", done, 1);
      chk("b2b_d1", d, 6);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_nogap_busy", busy, 1);
      chk("b2b_nogap_done", done, 0);
      repeat (3) @(negedge clk);
      chk("b2b_busy_pre", busy, 1);
      chk("b2b_hold", d, 6);
      @(negedge clk);
      chk("b2b_done2", done, 1);
      chk("b2b_d2", d, 0);
      chk("b2b_bout2", bout, 0);
      @(negedge clk);
      chk("b2b_pulse", done, 0);
      chk("b2b_idle", busy, 0);
      last_d = 4'd0;

      // Reset in the middle of an operation
      do_op("pre_rst", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 4'd3; b = 4'd9; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_d", d, 0);
      chk("mrst_bout", bout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mrst_nodone", done, 0);
         chk("mrst_nobusy", busy, 0);
      end
      last_d = 4'd0;
      do_op("post_rst", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0);

`ifdef RESTA_OVF_EN
      do_op("ovf8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
      chk("ovf8m1_ovf", ovf, 1);
      do_op("ovf5m2", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0);
      chk("ovf5m2_ovf", ovf, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
